// File: rtl/serial_adder_sub.sv
// Adder/subtractor that reuses one SLICE-bit full-adder slice across the word, with a registered
// carry between slices and valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per edge through the shared adder, LSB slice first
// DONE  | result presented, held until out_ready

module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder_sub: WIDTH must be at least 2");
        end
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("serial_adder_sub: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [SLICE:0]   slice_sum;
    logic             msb_cin;
    logic             last;
    logic [WIDTH-1:0] res_cat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (state == RUN) && (cnt == CNT_W'(N - 1));

    assign slice_sum = {1'b0, a_sr[SLICE-1:0]} + {1'b0, b_sr[SLICE-1:0]} + (SLICE + 1)'(carry);
    // Carry into the word MSB recovered from the top bit of the final slice: s = a ^ b ^ cin.
    assign msb_cin   = a_sr[SLICE-1] ^ b_sr[SLICE-1] ^ slice_sum[SLICE-1];

    // The last slice goes straight to the output, so the partial-result register only holds
    // the first N-1 slices.
    generate
        if (N > 1) begin : g_res
            logic [WIDTH-SLICE-1:0] res_sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_sr <= '0;
                end else if (state == RUN) begin
                    res_sr <= res_cat[WIDTH-1:SLICE];
                end
            end

            assign res_cat = {slice_sum[SLICE-1:0], res_sr};
        end else begin : g_res_single
            assign res_cat = slice_sum[SLICE-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> SLICE;
                    b_sr  <= b_sr >> SLICE;
                    carry <= slice_sum[SLICE];
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        sum  <= res_cat;
                        cout <= slice_sum[SLICE];
                        ovf  <= msb_cin ^ slice_sum[SLICE];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub: an 8-bit/1-bit-slice and a 16-bit/4-bit-slice instance,
// each checked against an arithmetic reference model.

module tb_serial_adder_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b0, in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        rst16 = 1'b0, in_valid16, in_ready16, sub16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    serial_adder_sub #(.WIDTH(8), .SLICE(1)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .ovf(ovf8)
    );

    serial_adder_sub #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .cout(cout16),
        .ovf(ovf16)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic        done8 = 1'b0;
    logic        done16 = 1'b0;
    logic [33:0] q8[$];
    logic [33:0] q16[$];
    logic [33:0] e8, e16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain w-bit arithmetic; packs {sum, cout, ovf}.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        longint unsigned mask, r;
        logic c, v, sx, sy, sr;
        mask = (64'd1 << w) - 64'd1;
        if (s) begin
            r = ({32'd0, x} - {32'd0, y}) & mask;
            c = (x >= y);
        end else begin
            r = {32'd0, x} + {32'd0, y};
            c = ((r >> w) & 64'd1) != 64'd0;
            r = r & mask;
        end
        sx = x[w-1];
        sy = y[w-1];
        sr = r[w-1];
        v  = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
        return {r[31:0], c, v};
    endfunction

    always @(negedge clk) begin
        if (!rst8 && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut8 unexpected output: got sum=%0h, expected no output", sum8);
            end else begin
                e8 = q8.pop_front();
                check("dut8 sum", 32'(sum8), e8[33:2]);
                check("dut8 cout", 32'(cout8), 32'(e8[1]));
                check("dut8 ovf", 32'(ovf8), 32'(e8[0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst16 && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut16 unexpected output: got sum=%0h, expected no output", sum16);
            end else begin
                e16 = q16.pop_front();
                check("dut16 sum", 32'(sum16), e16[33:2]);
                check("dut16 cout", 32'(cout16), 32'(e16[1]));
                check("dut16 ovf", 32'(ovf16), 32'(e16[0]));
            end
        end
    end

    // ---------------- 8-bit instance ----------------
    task automatic accept8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int k = 0;
        while (!in_ready8 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut8 in_ready wait: got timeout, expected in_ready");
        end
        a8 = x; b8 = y; sub8 = s; in_valid8 = 1'b1;
        q8.push_back(model(8, 32'(x), 32'(y), s));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic wait_out8();
        int k = 0;
        while (!out_valid8 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("dut8 latency", 32'(k), 32'd8);
    endtask

    task automatic dir8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [7:0] es, input logic ec, input logic ev);
        accept8(x, y, s);
        wait_out8();
        check("dut8 directed sum", 32'(sum8), 32'(es));
        check("dut8 directed cout", 32'(cout8), 32'(ec));
        check("dut8 directed ovf", 32'(ovf8), 32'(ev));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] hs;
        logic       hc, hv;
        int         n_hi;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
        #1 rst8 = 1'b1;
        #2;
        check("dut8 reset in_ready", 32'(in_ready8), 32'd1);
        check("dut8 reset out_valid", 32'(out_valid8), 32'd0);
        check("dut8 reset sum", 32'(sum8), 32'd0);
        check("dut8 reset cout", 32'(cout8), 32'd0);
        check("dut8 reset ovf", 32'(ovf8), 32'd0);
        #9 rst8 = 1'b0;
        @(posedge clk); #1;

        dir8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        dir8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        dir8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        dir8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Result stall with a dropped operand pulse in the middle.
        out_ready8 = 1'b0;
        accept8(8'h3C, 8'h5A, 1'b0);
        wait_out8();
        hs = sum8; hc = cout8; hv = ovf8;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
            end
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            check("dut8 stall sum", 32'(sum8), 32'(hs));
            check("dut8 stall cout", 32'(cout8), 32'(hc));
            check("dut8 stall ovf", 32'(ovf8), 32'(hv));
            check("dut8 stall out_valid", 32'(out_valid8), 32'd1);
            check("dut8 stall in_ready", 32'(in_ready8), 32'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("dut8 release out_valid", 32'(out_valid8), 32'd0);
        check("dut8 release in_ready", 32'(in_ready8), 32'd1);
        n_hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8) n_hi++;
        end
        check("dut8 dropped pulse outputs", 32'(n_hi), 32'd0);

        // Asynchronous reset in the middle of RUN.
        accept8(8'h21, 8'h43, 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        rst8 = 1'b1;
        #1;
        check("dut8 midrun in_ready", 32'(in_ready8), 32'd1);
        check("dut8 midrun out_valid", 32'(out_valid8), 32'd0);
        check("dut8 midrun sum", 32'(sum8), 32'd0);
        check("dut8 midrun cout", 32'(cout8), 32'd0);
        check("dut8 midrun ovf", 32'(ovf8), 32'd0);
        void'(q8.pop_back());
        @(negedge clk);
        rst8 = 1'b0;
        @(posedge clk); #1;
        dir8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            out_ready8 = 1'b0;
            accept8(8'($urandom), 8'($urandom), 1'($urandom));
            wait_out8();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            out_ready8 = 1'b1;
            @(posedge clk); #1;
        end
        done8 = 1'b1;
    end

    // ---------------- 16-bit instance ----------------
    task automatic accept16(input logic [15:0] x, input logic [15:0] y, input logic s);
        int k = 0;
        while (!in_ready16 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut16 in_ready wait: got timeout, expected in_ready");
        end
        a16 = x; b16 = y; sub16 = s; in_valid16 = 1'b1;
        q16.push_back(model(16, 32'(x), 32'(y), s));
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    endtask

    task automatic wait_out16();
        int k = 0;
        while (!out_valid16 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("dut16 latency", 32'(k), 32'd4);
    endtask

    initial begin
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; out_ready16 = 1'b1;
        #1 rst16 = 1'b1;
        #2;
        check("dut16 reset in_ready", 32'(in_ready16), 32'd1);
        check("dut16 reset out_valid", 32'(out_valid16), 32'd0);
        check("dut16 reset sum", 32'(sum16), 32'd0);
        #9 rst16 = 1'b0;
        @(posedge clk); #1;

        accept16(16'hFFFF, 16'h0001, 1'b0);
        wait_out16();
        check("dut16 directed sum", 32'(sum16), 32'h0000);
        check("dut16 directed cout", 32'(cout16), 32'd1);
        check("dut16 directed ovf", 32'(ovf16), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            out_ready16 = 1'($urandom);
            accept16(16'($urandom), 16'($urandom), 1'($urandom));
            wait_out16();
            if (!out_ready16) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                out_ready16 = 1'b1;
            end
            @(posedge clk); #1;
        end
        done16 = 1'b1;
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(done8 && done16) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(done8 && done16)) begin
            n_checks++;
            n_fail++;
            $display("FAIL watchdog: got timeout, expected both streams complete");
        end
        repeat (2) @(posedge clk);
        check("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
        check("dut16 scoreboard drained", 32'(q16.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
